// File: rtl/apb_pkg.sv
// Shared APB segment constants, FSM state encoding and address-window helper.
package apb_pkg;

    // Register space behind this master port (audioport segment).
    localparam logic [31:0] APB_START_ADDRESS   = 32'h8c00_0000;
    localparam logic [31:0] APB_END_ADDRESS     = 32'h8c00_04fc;
    // Wait states tolerated before a transfer is aborted with an error.
    localparam int          APB_MAX_WAIT_STATES = 32;
    localparam int          APB_WAIT_W          = $clog2(APB_MAX_WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    // True when the byte address falls inside the mapped window.
    function automatic logic in_window(input logic [31:0] addr);
        return (addr >= APB_START_ADDRESS) && (addr <= APB_END_ADDRESS);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin grant: searches from last_grant+1 upward, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    // First requester after the previous winner takes the grant.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NREQ requesters with round-robin arbitration,
// address-window filtering and a wait-state timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_write,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W-1:0]            prdata,
    input  logic                         pready,
    input  logic                         pslverr
);

    localparam int                    IDX_W      = $clog2(NREQ);
    localparam logic [APB_WAIT_W-1:0] WAIT_LIMIT = APB_WAIT_W'(APB_MAX_WAIT_STATES);

    apb_state_t             state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       owner;
    logic [APB_WAIT_W-1:0]  wait_cnt;
    logic [NREQ-1:0]        gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   any_req;
    logic                   accept;
    logic                   addr_ok;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    // Acceptance only happens in IDLE; held off while reset is asserted.
    assign accept    = (state == IDLE) && any_req && !rst;
    assign req_ready = accept ? gnt : '0;
    assign addr_ok   = in_window(32'(req_addr[gnt_idx]));

    // Transfer sequencer: grant, SETUP/ACCESS bus phases, one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NREQ - 1);
            owner      <= '0;
            wait_cnt   <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt_idx;
                        owner      <= gnt_idx;
                        if (addr_ok) begin
                            // Bus fields change only when a real cycle is issued.
                            psel   <= 1'b1;
                            pwrite <= req_write[gnt_idx];
                            paddr  <= req_addr[gnt_idx];
                            pwdata <= req_wdata[gnt_idx];
                            state  <= SETUP;
                        end else begin
                            rsp_valid <= gnt;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // Dead or unmapped slave: give up and report an error.
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
